// File: rtl/fht_input_loader_if.sv
// Sample stream and bank-write bus between the FHT input loader and its neighbours.
// The loader takes the slave view; the sample source / RAM side takes the master view.
interface fht_input_loader_if #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
);
    logic [D_BIT-1:0] iDATA;
    logic             iVALID;
    logic             oREADY;
    logic [A_BIT-1:0] oADDR;
    logic [D_BIT-1:0] oDATA;
    logic [3:0]       oWE;

    modport master (
        output iDATA, iVALID,
        input  oREADY, oADDR, oDATA, oWE
    );

    modport slave (
        input  iDATA, iVALID,
        output oREADY, oADDR, oDATA, oWE
    );
endinterface

// File: rtl/fht_input_loader.sv
// FHT front end: loads one frame of samples into the four input banks in bit-reversed
// order, fires the FHT control unit and holds off input until the transform completes.
module fht_input_loader #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
) (
    input  logic             iCLK,
    input  logic             iRESET,
    fht_input_loader_if.slave bus,
    input  logic             iFHT_RDY,
    output logic             oSTART,
    output logic             oBUSY,
    output logic             oDONE,
    output logic             oERR,
    output logic [A_BIT+2:0] oCNT
);
    typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT_ACK, WAIT_DONE} state_t;

    localparam logic [A_BIT+2:0] CNT_ONE = {{(A_BIT+2){1'b0}}, 1'b1};

    state_t           state, state_nxt;
    logic             accept;
    logic             ack_timeout;
    logic [2:0]       ack_cnt;
    logic [A_BIT+1:0] idx;
    logic [A_BIT+1:0] rev;

    always_comb begin
        idx = oCNT[A_BIT+1:0];
        rev = '0;
        for (int unsigned i = 0; i < A_BIT + 2; i++) begin
            rev[i] = idx[A_BIT+1-i];
        end
    end

    assign accept      = bus.iVALID && bus.oREADY;
    // Fifth consecutive cycle in WAIT_ACK with the controller still reporting ready.
    assign ack_timeout = (state == WAIT_ACK) && iFHT_RDY && (ack_cnt == 3'd4);

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        bus.oREADY = 1'b0;
        oBUSY      = 1'b0;
        case (state)
            IDLE: begin
                bus.oREADY = iFHT_RDY;
                if (bus.iVALID && iFHT_RDY) state_nxt = LOAD;
            end
            LOAD: begin
                bus.oREADY = 1'b1;
                if (bus.iVALID && (idx == '1)) state_nxt = FIRE;
            end
            FIRE: begin
                oBUSY     = 1'b1;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                oBUSY = 1'b1;
                if (!iFHT_RDY) state_nxt = WAIT_DONE;
                else if (ack_timeout) state_nxt = IDLE;
            end
            WAIT_DONE: begin
                oBUSY = 1'b1;
                if (iFHT_RDY) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            bus.oADDR <= '0;
            bus.oDATA <= '0;
            bus.oWE   <= '0;
            oSTART    <= 1'b0;
            oDONE     <= 1'b0;
            oERR      <= 1'b0;
            oCNT      <= '0;
            ack_cnt   <= '0;
        end else begin
            bus.oWE <= '0;
            oSTART  <= (state == FIRE);
            oDONE   <= 1'b0;
            ack_cnt <= (state == WAIT_ACK) ? ack_cnt + 3'd1 : '0;
            if (accept) begin
                bus.oWE   <= 4'b0001 << rev[A_BIT+1:A_BIT];
                bus.oADDR <= rev[A_BIT-1:0];
                bus.oDATA <= bus.iDATA;
                oCNT      <= oCNT + CNT_ONE;
            end
            if (state == LOAD && !iFHT_RDY) oERR <= 1'b1;
            if (ack_timeout) begin
                oERR <= 1'b1;
                oCNT <= '0;
            end
            if (state == WAIT_DONE && iFHT_RDY) begin
                oDONE <= 1'b1;
                oCNT  <= '0;
            end
        end
    end
endmodule

// File: tb/tb_fht_input_loader.sv
// Directed bench for fht_input_loader: bit-reversed mapping, FHT handshake, gaps,
// reset mid-frame and both protocol error paths.
module tb_fht_input_loader;
    logic        iCLK;
    logic        iRESET;
    logic        fht_rdy;
    logic        oSTART, oBUSY, oDONE, oERR;
    logic [10:0] oCNT;

    int vectors;
    int miscompares;

    int          hits     [1024];
    logic [15:0] ram      [1024];
    logic [3:0]  obs_we   [1024];
    logic [7:0]  obs_addr [1024];

    fht_input_loader_if #(.A_BIT(8), .D_BIT(16)) bus ();

    fht_input_loader #(.A_BIT(8), .D_BIT(16)) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .bus      (bus),
        .iFHT_RDY (fht_rdy),
        .oSTART   (oSTART),
        .oBUSY    (oBUSY),
        .oDONE    (oDONE),
        .oERR     (oERR),
        .oCNT     (oCNT)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] exp_we(input int n);
        logic [9:0] v, r;
        v = 10'(n);
        r = {<<{v}};
        return 4'b0001 << r[9:8];
    endfunction

    function automatic logic [7:0] exp_addr(input int n);
        logic [9:0] v, r;
        v = 10'(n);
        r = {<<{v}};
        return r[7:0];
    endfunction

    function automatic int we_to_bank(input logic [3:0] we);
        case (we)
            4'b0001: return 0;
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic do_reset(input int k);
        iRESET     = 1'b0;
        bus.iVALID = 1'b0;
        repeat (k) begin
            @(posedge iCLK); #1;
        end
        iRESET = 1'b1;
    endtask

    // Drives samples iDATA=n until nmax are accepted, checking every write and status cycle.
    task automatic load_frame(input int nmax, input int gap_pct);
        int n, pn, cyc, bank, idx, bad;
        logic pacc;
        logic [9:0] v, r;
        n = 0; pn = 0; cyc = 0; pacc = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            hits[i] = 0;
            ram[i]  = '0;
        end
        while ((n < nmax || pacc) && cyc < 20000) begin
            bus.iVALID = (n < nmax) && ($urandom_range(99) >= 32'(gap_pct));
            bus.iDATA  = 16'(n);
            @(negedge iCLK);
            vectors++;
            if (pacc) begin
                if (bus.oWE !== exp_we(pn) || bus.oADDR !== exp_addr(pn) || bus.oDATA !== 16'(pn)) begin
                    miscompares++;
                    $display("FAIL write n=%0d: got we=%b addr=%0d data=%0d, want we=%b addr=%0d data=%0d",
                             pn, bus.oWE, bus.oADDR, bus.oDATA, exp_we(pn), exp_addr(pn), pn);
                end
                bank = we_to_bank(bus.oWE);
                if (bank >= 0) begin
                    idx = bank * 256 + int'(bus.oADDR);
                    hits[idx]++;
                    ram[idx] = bus.oDATA;
                end
                obs_we[pn]   = bus.oWE;
                obs_addr[pn] = bus.oADDR;
            end else if (bus.oWE !== 4'b0000) begin
                miscompares++;
                $display("FAIL spurious_write n=%0d: got we=%b, want we=0000", n, bus.oWE);
            end
            vectors++;
            if (oCNT !== 11'(n) || bus.oREADY !== (n < 1024) || oBUSY !== (n == 1024) || oSTART !== 1'b0) begin
                miscompares++;
                $display("FAIL load_status n=%0d: got cnt=%0d ready=%b busy=%b start=%b, want cnt=%0d ready=%b busy=%b start=0",
                         n, oCNT, bus.oREADY, oBUSY, oSTART, n, (n < 1024), (n == 1024));
            end
            pacc = bus.iVALID;
            pn   = n;
            if (pacc) n++;
            cyc++;
            @(posedge iCLK); #1;
        end
        bus.iVALID = 1'b0;
        vectors++;
        if (cyc >= 20000) begin
            miscompares++;
            $display("FAIL load_timeout: got %0d accepts after %0d cycles, want %0d", n, cyc, nmax);
        end
        if (nmax == 1024) begin
            bad = 0;
            for (int i = 0; i < 1024; i++) begin
                v = 10'(i);
                r = {<<{v}};
                if (hits[i] != 1 || ram[i] !== {6'b0, r}) bad++;
            end
            vectors++;
            if (bad != 0) begin
                miscompares++;
                $display("FAIL ram_image: got %0d bad locations, want 0", bad);
            end
        end
    endtask

    // Entered in the oSTART cycle; the FHT model drops ready next cycle and raises it hold cycles later.
    task automatic finish_frame(input int hold);
        int bad;
        @(negedge iCLK);
        vectors++;
        if (oSTART !== 1'b1 || oBUSY !== 1'b1 || oCNT !== 11'd1024 || bus.oREADY !== 1'b0 || bus.oWE !== 4'b0000) begin
            miscompares++;
            $display("FAIL start: got start=%b busy=%b cnt=%0d ready=%b we=%b, want 1 1 1024 0 0000",
                     oSTART, oBUSY, oCNT, bus.oREADY, bus.oWE);
        end
        @(posedge iCLK); #1;
        fht_rdy    = 1'b0;
        bus.iVALID = 1'b1;
        bus.iDATA  = 16'hDEAD;
        bad = 0;
        repeat (hold) begin
            @(negedge iCLK);
            if (bus.oREADY !== 1'b0 || bus.oWE !== 4'b0000 || oCNT !== 11'd1024 ||
                oBUSY !== 1'b1 || oSTART !== 1'b0 || oDONE !== 1'b0) bad++;
            @(posedge iCLK); #1;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL held_off: got %0d bad busy cycles, want 0", bad);
        end
        fht_rdy    = 1'b1;
        bus.iVALID = 1'b0;
        @(negedge iCLK);
        vectors++;
        if (oDONE !== 1'b0 || oBUSY !== 1'b1) begin
            miscompares++;
            $display("FAIL done_early: got done=%b busy=%b, want 0 1", oDONE, oBUSY);
        end
        @(posedge iCLK); #1;
        @(negedge iCLK);
        vectors++;
        if (oDONE !== 1'b1 || oBUSY !== 1'b0 || oCNT !== 11'd0 || bus.oREADY !== 1'b1 || oERR !== 1'b0) begin
            miscompares++;
            $display("FAIL done: got done=%b busy=%b cnt=%0d ready=%b err=%b, want 1 0 0 1 0",
                     oDONE, oBUSY, oCNT, bus.oREADY, oERR);
        end
        @(posedge iCLK); #1;
        @(negedge iCLK);
        vectors++;
        if (oDONE !== 1'b0) begin
            miscompares++;
            $display("FAIL done_single: got done=%b, want 0", oDONE);
        end
        @(posedge iCLK); #1;
    endtask

    task automatic test_reset();
        do_reset(3);
        @(negedge iCLK);
        vectors++;
        if (bus.oWE !== 4'b0000 || bus.oADDR !== 8'd0 || bus.oDATA !== 16'd0 || oCNT !== 11'd0 ||
            oSTART !== 1'b0 || oBUSY !== 1'b0 || oDONE !== 1'b0 || oERR !== 1'b0 || bus.oREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL reset: got we=%b addr=%0d data=%0d cnt=%0d start=%b busy=%b done=%b err=%b ready=%b, want all 0 and ready=1",
                     bus.oWE, bus.oADDR, bus.oDATA, oCNT, oSTART, oBUSY, oDONE, oERR, bus.oREADY);
        end
        fht_rdy = 1'b0;
        #1;
        vectors++;
        if (bus.oREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_ready_follow: got ready=%b, want 0", bus.oREADY);
        end
        fht_rdy = 1'b1;
        @(posedge iCLK); #1;
    endtask

    task automatic test_mapping_frame();
        int          tn   [6] = '{0, 1, 2, 3, 4, 1023};
        logic [3:0]  twe  [6] = '{4'b0001, 4'b0100, 4'b0010, 4'b1000, 4'b0001, 4'b1000};
        logic [7:0]  tadr [6] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd128, 8'd255};
        do_reset(2);
        load_frame(1024, 0);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (obs_we[tn[i]] !== twe[i] || obs_addr[tn[i]] !== tadr[i]) begin
                miscompares++;
                $display("FAIL map n=%0d: got we=%b addr=%0d, want we=%b addr=%0d",
                         tn[i], obs_we[tn[i]], obs_addr[tn[i]], twe[i], tadr[i]);
            end
        end
        finish_frame(2600);
    endtask

    task automatic test_gapped();
        do_reset(2);
        load_frame(1024, 30);
        finish_frame(20);
    endtask

    task automatic test_reset_mid_frame();
        do_reset(2);
        load_frame(500, 0);
        do_reset(2);
        @(negedge iCLK);
        vectors++;
        if (oCNT !== 11'd0 || bus.oWE !== 4'b0000 || oBUSY !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: got cnt=%0d we=%b busy=%b, want 0 0000 0", oCNT, bus.oWE, oBUSY);
        end
        @(posedge iCLK); #1;
        load_frame(1024, 10);
        vectors++;
        if (obs_we[0] !== 4'b0001 || obs_addr[0] !== 8'd0 || oERR !== 1'b0) begin
            miscompares++;
            $display("FAIL restart_n0: got we=%b addr=%0d err=%b, want 0001 0 0", obs_we[0], obs_addr[0], oERR);
        end
        finish_frame(20);
    endtask

    task automatic test_err_drop();
        int bad;
        do_reset(2);
        load_frame(100, 0);
        bus.iVALID = 1'b1;
        bus.iDATA  = 16'd100;
        fht_rdy    = 1'b0;
        @(negedge iCLK);
        vectors++;
        if (bus.oREADY !== 1'b1 || oERR !== 1'b0) begin
            miscompares++;
            $display("FAIL drop_ready: got ready=%b err=%b, want 1 0", bus.oREADY, oERR);
        end
        @(posedge iCLK); #1;
        fht_rdy    = 1'b1;
        bus.iVALID = 1'b0;
        @(negedge iCLK);
        vectors++;
        if (bus.oWE !== 4'b0001 || bus.oADDR !== 8'd152 || bus.oDATA !== 16'd100 || oCNT !== 11'd101 || oERR !== 1'b1) begin
            miscompares++;
            $display("FAIL drop_accept: got we=%b addr=%0d data=%0d cnt=%0d err=%b, want 0001 152 100 101 1",
                     bus.oWE, bus.oADDR, bus.oDATA, oCNT, oERR);
        end
        bad = 0;
        repeat (10) begin
            @(posedge iCLK); #1;
            @(negedge iCLK);
            if (oERR !== 1'b1) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL err_sticky: got %0d cycles with err=0, want 0", bad);
        end
        @(posedge iCLK); #1;
        do_reset(2);
        @(negedge iCLK);
        vectors++;
        if (oERR !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: got err=%b, want 0", oERR);
        end
        @(posedge iCLK); #1;
    endtask

    task automatic test_err_noack();
        do_reset(2);
        load_frame(1024, 0);
        @(negedge iCLK);
        vectors++;
        if (oSTART !== 1'b1) begin
            miscompares++;
            $display("FAIL noack_start: got start=%b, want 1", oSTART);
        end
        for (int k = 1; k <= 5; k++) begin
            @(posedge iCLK); #1;
            @(negedge iCLK);
            vectors++;
            if (k < 5) begin
                if (oBUSY !== 1'b1 || oERR !== 1'b0 || oCNT !== 11'd1024) begin
                    miscompares++;
                    $display("FAIL noack_wait k=%0d: got busy=%b err=%b cnt=%0d, want 1 0 1024", k, oBUSY, oERR, oCNT);
                end
            end else if (oBUSY !== 1'b0 || oERR !== 1'b1 || oCNT !== 11'd0 || bus.oREADY !== 1'b1 || oDONE !== 1'b0) begin
                miscompares++;
                $display("FAIL noack_idle: got busy=%b err=%b cnt=%0d ready=%b done=%b, want 0 1 0 1 0",
                         oBUSY, oERR, oCNT, bus.oREADY, oDONE);
            end
        end
        @(posedge iCLK); #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        iRESET      = 1'b0;
        fht_rdy     = 1'b1;
        bus.iVALID  = 1'b0;
        bus.iDATA   = '0;
        test_reset();
        test_mapping_frame();
        test_gapped();
        test_reset_mid_frame();
        test_err_drop();
        test_err_noack();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
